mul_arbiter: RTL
================

# mul_arbiter

Round-robin controller that shares one `mult_8` sequential multiplier between `NREQ` requesters. It accepts operand pairs, grants the multiplier to one requester at a time, and pulses `mult_8` start with the granted operands. It waits a fixed number of cycles for the product, then returns the 16-bit result with a one-cycle done pulse. It sits between client blocks and the multiplier and owns all of the multiplier's control inputs.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `W`, 8: operand width; product width is 2W.
- `MUL_LAT`, 9: cycles `mult_8` needs from the end of its start pulse until `op` is valid and stable.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `req` in NREQ: per-requester request level. Bit i is held high with operands stable until `done[i]`.
- `a_in` in NREQ*W: operand A; requester i occupies bits [i*W +: W].
- `b_in` in NREQ*W: operand B, same packing as `a_in`.
- `gnt` out NREQ: one-hot grant, high from grant through the done cycle.
- `done` out NREQ: one-cycle pulse; `result` is valid in the same cycle.
- `result` out 2W: product register; holds its last value until the next capture.
- `busy` out 1: high whenever state is not IDLE.
- `mul_start` out 1: to `mult_8` start.
- `mul_a` out W: to `mult_8` a.
- `mul_b` out W: to `mult_8` b.
- `mul_op` in 2W: from `mult_8` op.

## Operation
- States: IDLE, START, WAIT, DONE.
- IDLE
  - If any `req` bit is high, pick the winner by round-robin. The search starts at index (last+1) mod NREQ, where last is the most recently granted index.
  - Register the winner's operands into `mul_a`/`mul_b`, set `gnt`, update last, and go to START.
  - If no request is pending, stay in IDLE.
- START
  - `mul_start`=1 for exactly this one cycle.
  - Load the wait counter with MUL_LAT-1 and go to WAIT.
- WAIT
  - Decrement the counter each cycle.
  - When the counter is 0, capture `mul_op` into `result` and go to DONE.
- DONE
  - `done[winner]`=1 for this cycle and `gnt` is still asserted.
  - Go to IDLE; requests are not sampled in DONE.
- Operand latching
  - Operands are latched at grant.
  - Changes on `a_in`/`b_in` or `req` after grant do not affect the operation in flight.
  - A requester dropping `req` early still gets its `done` pulse.
- Re-requests
  - A requester still holding `req` in the cycle after `done` is treated as a new request.
  - Round-robin serves other pending requesters first.
- `mul_a`/`mul_b` hold their values until the next grant.
- Arithmetic is unsigned. `result` is the full 2W-bit `mul_op`, with no truncation and no overflow handling.
- Reset (async low)
  - State goes to IDLE and the counter clears.
  - `gnt`, `done`, `busy` and `mul_start` go to 0.
  - `mul_a`, `mul_b` and `result` go to 0.
  - last goes to NREQ-1, so requester 0 wins the first arbitration.
- Reset mid-operation aborts the operation with no `done` pulse. The integrator must reset `mult_8` together with this block.

## Timing
- Edge numbering: E0 is the edge that samples `req` in IDLE.
- E0: `gnt`, `busy`, `mul_a` and `mul_b` become valid in the following cycle.
- `mul_start` is high between E1 and the edge after it.
- WAIT occupies MUL_LAT cycles.
- Edge E(MUL_LAT+1) captures `result`; `done` is high in the cycle after that edge.
- Request-to-done latency: MUL_LAT+2 edges after E0.
- Back-to-back throughput: one product per MUL_LAT+3 cycles, since the next arbitration happens in the IDLE cycle after DONE.
- Simultaneous requests: exactly one grant; no requester waits more than NREQ-1 operations.
- Reset release: the first arbitration occurs on the first rising edge with `reset` high.

## Test plan
- Single request
  - Stimulus: `req`=0001, a0=9, b0=13.
  - Required: `mul_start` is a single pulse with `mul_a`=9, `mul_b`=13.
  - Required: `done`=0001 exactly 11 edges after E0, with `result`=117 (0x0075); `busy` then drops.
- All four requesting at once
  - Stimulus: a=255/2/0/16, b=255/3/77/16 for requesters 0..3.
  - Required: grants in order 0,1,2,3.
  - Required: results 65025 (0xFE01), 6, 0, 256, each `done` 12 cycles apart.
- Fairness
  - Stimulus: requesters 0 and 2 hold `req` continuously.
  - Required: grants alternate 0,2,0,2; requester 2 never waits more than one operation.
- Operand change after grant
  - Stimulus: change a1 from 5 to 7 and drop `req[1]` during WAIT.
  - Required: `result` uses a1=5, and `done[1]` still pulses.
- Reset mid-operation
  - Stimulus: assert `reset` low during WAIT.
  - Required: all outputs go to 0 asynchronously, before the next edge, with no `done` pulse.
  - Required: after release, a pending `req[3]` is not favoured and requester 0 wins if it is also requesting.
- Idle stability
  - Stimulus: `req`=0 for 50 cycles.
  - Required: `mul_start`, `gnt`, `done` and `busy` stay 0, and `result` holds its previous value.

Source files
------------

// File: rtl/mul_arbiter.sv
// Round-robin controller sharing one sequential multiplier among NREQ requesters.
// Latches the winner's operands, pulses start, waits MUL_LAT cycles, then returns the product.
module mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int MUL_LAT = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] a_in,
  input  logic [NREQ*W-1:0] b_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*W-1:0]    result,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_op
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MUL_LAT + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [NREQ-1:0] GNT_ONE = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   last_r;
  logic [CW-1:0]   cnt_r;
  logic [IW-1:0]   win_s;
  logic            found_s;

  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int step);
    return IW'((int'(base) + step) % NREQ);
  endfunction

  // Round-robin pick: scanning down means the smallest step after last wins.
  always_comb begin
    win_s   = last_r;
    found_s = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      win_s   = req[rr_index(last_r, k)] ? rr_index(last_r, k) : win_s;
      found_s = found_s | req[rr_index(last_r, k)];
    end
  end

  // Control FSM; every output is registered and follows the state it accompanies.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= IDLE;
      last_r    <= LAST_RST;
      cnt_r     <= '0;
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      busy      <= 1'b0;
      mul_start <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
    end else begin
      mul_start <= 1'b0;
      done      <= '0;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            mul_a   <= a_in[win_s*W +: W];
            mul_b   <= b_in[win_s*W +: W];
            gnt     <= GNT_ONE << win_s;
            last_r  <= win_s;
            busy    <= 1'b1;
            state_r <= START;
          end else begin
            state_r <= IDLE;
          end
        end
        START: begin
          mul_start <= 1'b1;
          cnt_r     <= CNT_LOAD;
          state_r   <= WAIT;
        end
        WAIT: begin
          if (cnt_r == '0) begin
            result  <= mul_op;
            done    <= gnt;
            state_r <= DONE;
          end else begin
            cnt_r   <= cnt_r - CNT_ONE;
          end
        end
        DONE: begin
          gnt     <= '0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          gnt     <= '0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end
endmodule
